uart_tx_arbiter: RTL



---
 rtl/uart_tx_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Purpose : round-robin scheduler of the UART transmitter between RF read data (1 byte) and ALU results (2 bytes, LSB first).
// Latency : source valid at cycle N -> pending at N+1 -> TX_Data_Valid at N+2 when idle and TX_Busy is low.
// Backpr. : one-entry buffer per source; a valid arriving while that buffer is still occupied is dropped and flagged on *_Drop.
//
// Ports:
//   CLK, RST                    clock (rising edge), asynchronous active-low reset
//   RdData / RdData_Valid       register-file read byte and its one-cycle strobe
//   ALU_OUT / ALU_OUT_Valid     ALU result word and its one-cycle strobe
//   TX_Busy                     UART transmitter busy, already in the CLK domain
//   TX_P_Data / TX_Data_Valid   registered byte to the UART and its one-cycle strobe
//   clk_div_en                  UART clock-divider enable while traffic is outstanding
//   RF_Drop / ALU_Drop          one-cycle pulses, a source strobe was lost to a full buffer
module uart_tx_arbiter #(
  parameter int DATA_WIDTH   = 8,
  parameter int OUT_WIDTH    = 16,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RdData,
  input  logic                  RdData_Valid,
  input  logic [OUT_WIDTH-1:0]  ALU_OUT,
  input  logic                  ALU_OUT_Valid,
  input  logic                  TX_Busy,
  output logic [DATA_WIDTH-1:0] TX_P_Data,
  output logic                  TX_Data_Valid,
  output logic                  clk_div_en,
  output logic                  RF_Drop,
  output logic                  ALU_Drop
);

  localparam int CW = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;

  state_t                state, state_nxt;
  logic                  rf_pend, alu_pend;
  logic [DATA_WIDTH-1:0] rf_buf;
  logic [OUT_WIDTH-1:0]  alu_buf;
  logic                  last_alu;   // 1: ALU was served last
  logic                  grant_alu;  // source of the transaction in flight
  logic                  byte_idx;   // 0: ALU low byte, 1: ALU high byte
  logic [CW-1:0]         busy_cnt;

  logic grant, pick_alu, load_hi, done, cnt_clr, cnt_inc;
  logic rf_clr, alu_clr;

  // A tie goes to the source not served last; a lone requester always wins.
  assign pick_alu = alu_pend & (~rf_pend | ~last_alu);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    load_hi   = 1'b0;
    done      = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (!TX_Busy && (rf_pend || alu_pend)) begin
          grant     = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        cnt_clr   = 1'b1;
        state_nxt = WAIT_HI;
      end
      WAIT_HI: begin
        // A UART that never raises busy is assumed to have taken the byte.
        if (TX_Busy || busy_cnt == CW'(BUSY_TIMEOUT - 1)) state_nxt = WAIT_LO;
        else                                             cnt_inc   = 1'b1;
      end
      WAIT_LO: begin
        if (!TX_Busy) begin
          if (grant_alu && !byte_idx) begin
            load_hi   = 1'b1;
            state_nxt = SEND;
          end else begin
            done      = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign TX_Data_Valid = (state == SEND);
  assign clk_div_en    = rf_pend | alu_pend | (state != IDLE);

  // The buffer of the finishing source frees up in the same cycle, so a new
  // strobe arriving then is captured instead of dropped.
  assign rf_clr  = done & ~grant_alu;
  assign alu_clr = done &  grant_alu;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rf_pend   <= 1'b0;
      rf_buf    <= '0;
      alu_pend  <= 1'b0;
      alu_buf   <= '0;
      RF_Drop   <= 1'b0;
      ALU_Drop  <= 1'b0;
      last_alu  <= 1'b1;
      grant_alu <= 1'b0;
      byte_idx  <= 1'b0;
      busy_cnt  <= '0;
      TX_P_Data <= '1;
    end else begin
      RF_Drop  <= 1'b0;
      ALU_Drop <= 1'b0;

      if (RdData_Valid && (!rf_pend || rf_clr)) begin
        rf_buf  <= RdData;
        rf_pend <= 1'b1;
      end else if (RdData_Valid) begin
        RF_Drop <= 1'b1;
      end else if (rf_clr) begin
        rf_pend <= 1'b0;
      end

      if (ALU_OUT_Valid && (!alu_pend || alu_clr)) begin
        alu_buf  <= ALU_OUT;
        alu_pend <= 1'b1;
      end else if (ALU_OUT_Valid) begin
        ALU_Drop <= 1'b1;
      end else if (alu_clr) begin
        alu_pend <= 1'b0;
      end

      if (grant) begin
        grant_alu <= pick_alu;
        byte_idx  <= 1'b0;
        TX_P_Data <= pick_alu ? alu_buf[DATA_WIDTH-1:0] : rf_buf;
      end

      // High byte comes from the captured word; the live ALU_OUT may have moved on.
      if (load_hi) begin
        byte_idx  <= 1'b1;
        TX_P_Data <= alu_buf[OUT_WIDTH-1:DATA_WIDTH];
      end

      if (done) last_alu <= grant_alu;

      if (cnt_clr)      busy_cnt <= '0;
      else if (cnt_inc) busy_cnt <= busy_cnt + CW'(1);
    end
  end

endmodule
